// File: rtl/dbus_bridge_if.sv
//------------------------------------------------------------------------------
// Module  : dbus_bridge_if
// Brief   : Core-side load/store signals and slave-side bus signals of the bridge
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dbus_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 2
);
    logic                           MemRead;
    logic                           MemWrite;
    logic [ADDR_WIDTH-1:0]          m_addr;
    logic [DATA_WIDTH-1:0]          m_wr_dat;
    logic [DATA_WIDTH/8-1:0]        m_be;
    logic [DATA_WIDTH-1:0]          m_rd_dat;
    logic                           m_ready;
    logic                           m_err;

    logic [NUM_SLAVES-1:0]          s_sel;
    logic                           s_rd_en;
    logic                           s_wr_en;
    logic [ADDR_WIDTH-1:0]          s_addr;
    logic [DATA_WIDTH-1:0]          s_wr_dat;
    logic [DATA_WIDTH/8-1:0]        s_be;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rd_dat;
    logic [NUM_SLAVES-1:0]          s_ack;

    // Bridge view: serves the core, drives the slaves
    modport slave (
        input  MemRead, MemWrite, m_addr, m_wr_dat, m_be, s_rd_dat, s_ack,
        output m_rd_dat, m_ready, m_err, s_sel, s_rd_en, s_wr_en, s_addr,
               s_wr_dat, s_be
    );

    // Environment view: core requests plus slave responses
    modport master (
        output MemRead, MemWrite, m_addr, m_wr_dat, m_be, s_rd_dat, s_ack,
        input  m_rd_dat, m_ready, m_err, s_sel, s_rd_en, s_wr_en, s_addr,
               s_wr_dat, s_be
    );
endinterface

`default_nettype wire

// File: rtl/dbus_bridge.sv
//------------------------------------------------------------------------------
// Module  : dbus_bridge
// Brief   : Decodes core load/store requests onto NUM_SLAVES memory-mapped slaves
//           with ack handshake, byte enables, and unmapped/timeout error response
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dbus_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h8000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_0000},
    parameter int TIMEOUT    = 15
) (
    input  logic            clk,
    input  logic            reset,
    dbus_bridge_if.slave    bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ERR    = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [NUM_SLAVES-1:0] sel_q,   sel_d;
    logic                  wr_q,    wr_d;
    logic                  err_q,   err_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdat_q,  wdat_d;
    logic [BE_W-1:0]       be_q,    be_d;
    logic [DATA_WIDTH-1:0] rdat_q,  rdat_d;

    logic [NUM_SLAVES-1:0] w_match_sel;
    logic [ADDR_WIDTH-1:0] w_match_mask;
    logic [DATA_WIDTH-1:0] w_slv_rdat;
    logic                  w_ack;

    // Scanning from the top index down lets the lowest matching slave win
    always_comb begin
        w_match_sel  = '0;
        w_match_mask = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_match_sel    = '0;
                w_match_sel[i] = 1'b1;
                w_match_mask   = SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        w_slv_rdat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                w_slv_rdat = w_slv_rdat | bus.s_rd_dat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_ack = |(bus.s_ack & sel_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            be_q    <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            be_q    <= be_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        be_d    = be_q;
        rdat_d  = rdat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.MemRead ^ bus.MemWrite) begin
                    wr_d   = bus.MemWrite;
                    addr_d = bus.m_addr & ~w_match_mask;
                    wdat_d = bus.m_wr_dat;
                    be_d   = bus.m_be;
                    sel_d  = w_match_sel;
                    if (|w_match_sel) begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ERR;
                    end
                end else if (bus.MemRead && bus.MemWrite) begin
                    state_d = S_ERR;
                end
            end
            S_ACCESS: begin
                // An ack on the same cycle the counter expires takes priority
                if (w_ack) begin
                    if (!wr_q) begin
                        rdat_d = w_slv_rdat;
                    end
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ERR: begin
                err_d   = 1'b1;
                rdat_d  = '0;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.s_sel    = (state_q == S_ACCESS) ? sel_q : '0;
        bus.s_rd_en  = (state_q == S_ACCESS) && !wr_q;
        bus.s_wr_en  = (state_q == S_ACCESS) && wr_q;
        bus.s_addr   = addr_q;
        bus.s_wr_dat = wdat_q;
        bus.s_be     = be_q;
        bus.m_ready  = (state_q == S_RESP);
        bus.m_err    = (state_q == S_RESP) && err_q;
        bus.m_rd_dat = rdat_q;
    end

endmodule

`default_nettype wire

// File: doc/dbus_bridge.md
# dbus_bridge

Parametrised data-bus bridge between the core's load/store port (MemRead/MemWrite/m_addr/m_wr_dat/m_rd_dat) and NUM_SLAVES memory-mapped slaves (data memory, CSR-mapped peripherals, future I/O). It replaces the fixed single-memory hookup in the top-level wrapper with:

- address decoding;
- a ready/ack handshake that tolerates variable slave wait states;
- byte enables;
- an error response for unmapped addresses and timed-out accesses.

## Interface

Parameters:

- DATA_WIDTH, 32, data bus width; must be a multiple of 8
- ADDR_WIDTH, 32, address width
- NUM_SLAVES, 2, number of slave ports (1..8)
- SLAVE_BASE, {32'h8000_0000, 32'h0000_0000}, packed NUM_SLAVES×ADDR_WIDTH base addresses; slave i is at slice i
- SLAVE_MASK, {32'hFFFF_F000, 32'hFFFF_0000}, packed region masks; slave i matches when (m_addr & MASK[i]) == BASE[i]
- TIMEOUT, 15, maximum ACCESS cycles without ack before an error response; 0 disables the timeout

Ports:

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous reset, active-low
- MemRead  in  1  core read request; held until m_ready
- MemWrite  in  1  core write request; held until m_ready
- m_addr  in  ADDR_WIDTH  byte address
- m_wr_dat  in  DATA_WIDTH  write data
- m_be  in  DATA_WIDTH/8  byte enables for writes
- m_rd_dat  out  DATA_WIDTH  read data, valid while m_ready=1 and m_err=0
- m_ready  out  1  one-cycle completion pulse
- m_err  out  1  error flag, valid only with m_ready
- s_sel  out  NUM_SLAVES  one-hot slave select
- s_rd_en  out  1  slave read strobe
- s_wr_en  out  1  slave write strobe
- s_addr  out  ADDR_WIDTH  offset within the region, m_addr & ~MASK[i]
- s_wr_dat  out  DATA_WIDTH  registered write data
- s_be  out  DATA_WIDTH/8  registered byte enables
- s_rd_dat  in  NUM_SLAVES×DATA_WIDTH  packed slave read data
- s_ack  in  NUM_SLAVES  per-slave completion; slave i may assert it when s_sel[i]=1

## Operation

The FSM has four states: IDLE, ACCESS, ERR, RESP.

- **IDLE:**
  - If MemRead^MemWrite is 1, latch the address, write data, byte enables and direction.
  - Decode the address. If several slaves match, the lowest index wins.
  - On a match, go to ACCESS and clear the timeout counter.
  - With no match, or with MemRead&MemWrite both 1, go to ERR.
- **ACCESS:**
  - Drive s_sel one-hot, plus s_rd_en or s_wr_en, from registers; s_addr/s_wr_dat/s_be are stable for the whole state.
  - When the selected slave's s_ack is 1: capture its s_rd_dat slice (reads only), drop all slave strobes and go to RESP with err=0.
  - Acks from unselected slaves are ignored.
  - The counter increments every ACCESS cycle without an ack. If TIMEOUT≠0 and the counter reaches TIMEOUT, drop the strobes and go to ERR.
- **ERR:**
  - Set the error flag and go to RESP. No slave strobe is driven.
- **RESP:**
  - m_ready=1 for exactly one cycle, with m_err reflecting the error flag.
  - On an error, m_rd_dat=0.
  - Always return to IDLE. A request still asserted during RESP is ignored.

Additional rules:

- m_rd_dat holds its last value outside RESP, except that it is cleared by reset.
- s_rd_dat is sampled only in ACCESS on the cycle the selected slave acks.
- Writes return m_rd_dat unchanged.

## Timing

- Reset (reset=0, asynchronous), state forced immediately:
  - FSM=IDLE, counter=0.
  - m_ready=0, m_err=0, m_rd_dat=0.
  - s_sel=0, s_rd_en=0, s_wr_en=0, s_addr=0, s_wr_dat=0, s_be=0.
- Reset mid-transaction: the slave strobes drop asynchronously and the transaction is abandoned with no m_ready.
- Release is synchronous to the next clk edge.
- Request sampled at edge E0 → slave strobes visible after E0.
- A slave acking in its first selected cycle is sampled at E1 → m_ready after E1. Minimum latency is 2 cycles from request sample to m_ready.
- Each wait state adds one cycle: latency = 2 + w, where w = cycles the ack is delayed.
- Unmapped access: ERR after E0, m_ready/m_err after E1 (latency 2).
- Timeout: m_ready/m_err asserted TIMEOUT+2 cycles after the request sample.
- Back-to-back requests: the core drops or changes its request in the cycle after m_ready. The next request is sampled in IDLE, one cycle after RESP, giving a peak throughput of one access per 3 cycles.
- An ack arriving in the same cycle the counter hits TIMEOUT wins: no error.

## Test plan

- Read from slave 0, addr 0x0000_0010, s_ack in the first cycle with data 0xDEAD_BEEF → s_sel=01, s_addr=0x10, m_ready 2 cycles after the request, m_rd_dat=0xDEAD_BEEF, m_err=0.
- Write to slave 1, addr 0x8000_0ABC, data 0x1234_5678, m_be=4'b0011, ack after 3 wait states → s_sel=10, s_addr=0xABC, s_wr_en held 4 cycles, s_be=0011, m_ready at cycle 5, m_err=0.
- Read from unmapped addr 0x4000_0000 → no s_sel ever asserted, m_ready+m_err at cycle 2, m_rd_dat=0.
- Read from slave 0 that never acks, TIMEOUT=15 → strobes held 15 cycles then dropped, m_ready+m_err at cycle 17. A stray s_ack[1] during the wait is ignored.
- MemRead and MemWrite both high → error response at latency 2. Then a back-to-back legal read is issued the cycle after m_ready → accepted and completes normally.
- reset pulled low while ACCESS waits on slave 1 → s_sel/s_wr_en drop in the same cycle and no m_ready appears. After release, a new read completes correctly.
